// File: rtl/line_readout_pkg.sv
// Shared types and header-word layout for the line readout scheduler.
package line_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        STREAM,
        DRAIN
    } state_t;

    localparam logic [1:0] HDR_TAG       = 2'b10;
    localparam int         HDR_TAG_LSB   = 30;
    localparam int         HDR_SOF_BIT   = 29;
    localparam int         HDR_CNT_LSB   = 16;
    localparam int         HDR_WORDS_LSB = 0;

    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    // Bit 28 is reserved and always zero.
    function automatic logic [31:0] make_header(
        input logic        sof,
        input logic [11:0] line_cnt,
        input logic [15:0] words
    );
        logic [31:0] hdr;
        hdr                        = '0;
        hdr[HDR_TAG_LSB +: 2]      = HDR_TAG;
        hdr[HDR_SOF_BIT]           = sof;
        hdr[HDR_CNT_LSB +: 12]     = line_cnt;
        hdr[HDR_WORDS_LSB +: 16]   = words;
        return hdr;
    endfunction

endpackage

// File: rtl/line_readout_fifo.sv
// Two-entry output FIFO; the head entry is the registered stream data.
module line_readout_fifo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic [1:0]  count_o
);

    logic [31:0] tail;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            tail    <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            count_o <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_o == 2'd0) data_o <= push_data_i;
                    else                 tail   <= push_data_i;
                    count_o <= count_o + 2'd1;
                end
                2'b01: begin
                    data_o  <= tail;
                    count_o <= count_o - 2'd1;
                end
                2'b11: begin
                    if (count_o == 2'd1) begin
                        data_o <= push_data_i;
                    end else begin
                        data_o <= tail;
                        tail   <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o = (count_o != 2'd0);

endmodule

// File: rtl/line_readout_scheduler.sv
// Flow-controlled reader of the ping-pong line RAMs: queues completed lines,
// emits a header word per line and streams the line words to the receiver.
module line_readout_scheduler
    import line_readout_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  frame_start_i,
    input  logic                  line_ready_i,
    input  logic                  line_bank_i,
    input  logic [ADDR_WIDTH-1:0] line_words_i,
    output logic                  rd_en_o,
    output logic                  rd_bank_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [31:0]           rd_data_i,
    output logic [31:0]           out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic [7:0]            overrun_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_t                  state;
    logic                    pend_valid;
    logic                    pend_bank;
    logic [ADDR_WIDTH-1:0]   pend_words;
    logic [ADDR_WIDTH-1:0]   act_words;
    logic                    in_flight;
    logic [CNT_WIDTH-1:0]    line_cnt;
    logic                    sof;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [31:0]             fifo_din;
    logic [1:0]              fifo_count;
    logic [1:0]              committed;
    logic                    can_issue;
    logic                    fifo_space;
    logic                    hdr_push;
    logic                    take_pending;
    logic                    take_direct;
    logic                    store_line;
    logic                    drop_line;

    // A read issued now lands next cycle, so it may only go out if the FIFO is
    // guaranteed a free entry by then counting only pops already happening.
    assign fifo_pop   = out_valid_o && out_ready_i;
    assign committed  = fifo_count + {1'b0, in_flight};
    assign can_issue  = (committed < FIFO_DEPTH) || ((committed == FIFO_DEPTH) && fifo_pop);
    assign fifo_space = (fifo_count < FIFO_DEPTH) || fifo_pop;
    assign hdr_push   = (state == HEADER) && fifo_space;
    assign rd_en_o    = (state == STREAM) && can_issue;
    assign fifo_push  = hdr_push || in_flight;
    assign fifo_din   = in_flight ? rd_data_i
                                  : make_header(sof, 12'(line_cnt), 16'(act_words));

    assign take_pending = (state == IDLE) && pend_valid;
    assign take_direct  = (state == IDLE) && !pend_valid && line_ready_i;
    assign store_line   = line_ready_i && !take_direct && (!pend_valid || take_pending);
    assign drop_line    = line_ready_i && !take_direct && pend_valid && !take_pending;

    assign busy_o = (state != IDLE) || out_valid_o;

    line_readout_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (frame_start_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_din),
        .pop_i       (fifo_pop),
        .data_o      (out_data_o),
        .valid_o     (out_valid_o),
        .count_o     (fifo_count)
    );

    // A frame start discards everything in progress; a line arriving with it
    // lands in the freshly emptied pending slot as line 0 of the new frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pend_valid    <= 1'b0;
            pend_bank     <= 1'b0;
            pend_words    <= '0;
            act_words     <= '0;
            rd_bank_o     <= 1'b0;
            rd_addr_o     <= '0;
            in_flight     <= 1'b0;
            line_cnt      <= '0;
            sof           <= 1'b1;
            overrun_cnt_o <= '0;
        end else if (frame_start_i) begin
            state      <= IDLE;
            pend_valid <= line_ready_i;
            pend_bank  <= line_bank_i;
            pend_words <= line_words_i;
            in_flight  <= 1'b0;
            line_cnt   <= '0;
            sof        <= 1'b1;
        end else begin
            in_flight <= rd_en_o;

            if (drop_line && (overrun_cnt_o != 8'hFF))
                overrun_cnt_o <= overrun_cnt_o + 8'd1;

            if (store_line) begin
                pend_valid <= 1'b1;
                pend_bank  <= line_bank_i;
                pend_words <= line_words_i;
            end else if (take_pending) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (take_pending) begin
                        act_words <= pend_words;
                        rd_bank_o <= pend_bank;
                        rd_addr_o <= '0;
                        state     <= HEADER;
                    end else if (take_direct) begin
                        act_words <= line_words_i;
                        rd_bank_o <= line_bank_i;
                        rd_addr_o <= '0;
                        state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (hdr_push) begin
                        if (act_words == '0) begin
                            line_cnt <= line_cnt + CNT_ONE;
                            state    <= IDLE;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (rd_en_o) begin
                        if (rd_addr_o == act_words - ADDR_ONE) state <= DRAIN;
                        else                                   rd_addr_o <= rd_addr_o + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    // The last read always lands during this single cycle.
                    line_cnt <= line_cnt + CNT_ONE;
                    sof      <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_readout_scheduler.sv
// Directed self-checking bench for line_readout_scheduler with a simple RAM
// model and a transfer monitor that also checks data stability under stalls.
module tb_line_readout_scheduler;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        line_ready;
    logic        line_bank;
    logic [11:0] line_words;
    logic        rd_en;
    logic        rd_bank;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] got[$];
    logic [31:0] exp[$];
    int          rdEnCount;
    logic        stalledPrev;
    logic        abortPrev;
    logic [31:0] heldData;
    logic        readyLevel;
    logic        toggleReady;
    logic        found;

    line_readout_scheduler #(.ADDR_WIDTH(12), .CNT_WIDTH(12)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (frame_start),
        .line_ready_i  (line_ready),
        .line_bank_i   (line_bank),
        .line_words_i  (line_words),
        .rd_en_o       (rd_en),
        .rd_bank_o     (rd_bank),
        .rd_addr_o     (rd_addr),
        .rd_data_i     (rd_data),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .busy_o        (busy),
        .overrun_cnt_o (overrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ramWord(input logic bank, input logic [11:0] addr);
        return {15'h0, bank, 4'h5, addr};
    endfunction

    always @(posedge clk)
        rd_data <= rd_en ? ramWord(rd_bank, rd_addr) : 32'hDEAD_BEEF;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (toggleReady) out_ready = ~out_ready;
            else             out_ready = readyLevel;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalledPrev = 1'b0;
            abortPrev   = 1'b0;
        end else begin
            if (stalledPrev && !abortPrev) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", out_data, heldData);
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (rd_en) rdEnCount++;
            stalledPrev = out_valid && !out_ready;
            heldData    = out_data;
            abortPrev   = frame_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic fs, input logic lr, input logic bank, input logic [11:0] words);
        frame_start = fs;
        line_ready  = lr;
        line_bank   = bank;
        line_words  = words;
        tick();
        frame_start = 1'b0;
        line_ready  = 1'b0;
    endtask

    task automatic expectLine(input logic [31:0] hdr, input logic bank, input int n);
        exp.push_back(hdr);
        for (int i = 0; i < n; i++) exp.push_back(ramWord(bank, 12'(i)));
    endtask

    task automatic waitAndCompare(input int budget);
        int cycles;
        cycles = 0;
        while (got.size() < exp.size() && cycles < budget) begin
            @(posedge clk);
            cycles++;
        end
        repeat (6) @(posedge clk);
        #2;
        checkOutput("stream_len", 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            checkOutput($sformatf("word%0d", i), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp[i]);
        got.delete();
        exp.delete();
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        line_ready  = 1'b0;
        line_bank   = 1'b0;
        line_words  = '0;
        out_ready   = 1'b1;
        readyLevel  = 1'b1;
        toggleReady = 1'b0;
        stalledPrev = 1'b0;
        abortPrev   = 1'b0;
        heldData    = '0;
        rdEnCount   = 0;
        found       = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", out_data, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun_cnt), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
        tick();

        // Single 4-word line with exact latency checks.
        expectLine(32'hA000_0004, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd4);
        @(negedge clk);
        checkOutput("hdr_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("hdr_valid", 32'(out_valid), 32'd1);
        checkOutput("hdr_data", out_data, 32'hA000_0004);
        checkOutput("first_rd_en", 32'(rd_en), 32'd1);
        checkOutput("first_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        checkOutput("gap_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("pix0_valid", 32'(out_valid), 32'd1);
        checkOutput("pix0_data", out_data, ramWord(1'b0, 12'd0));
        waitAndCompare(100);
        checkOutput("busy_idle", 32'(busy), 32'd0);

        // Two back-to-back lines under toggling backpressure.
        toggleReady = 1'b1;
        expectLine(32'h8001_0003, 1'b1, 3);
        expectLine(32'h8002_0002, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd2);
        waitAndCompare(200);
        toggleReady = 1'b0;
        readyLevel  = 1'b1;
        tick();

        // Three lines during a long one: second queued, third dropped.
        expectLine(32'h8003_0040, 1'b0, 64);
        expectLine(32'h8004_0005, 1'b1, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd64);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd5);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd7);
        waitAndCompare(400);
        checkOutput("overrun_one", 32'(overrun_cnt), 32'd1);

        // Zero-word line: header only.
        rdEnCount = 0;
        expectLine(32'h8005_0000, 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd0);
        waitAndCompare(50);
        checkOutput("no_reads", 32'(rdEnCount), 32'd0);

        // Abort mid-stream at address 10.
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd32);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (rd_addr == 12'd10) found = 1'b1;
            else tick();
        end
        checkOutput("abort_reach", 32'(found), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd_en", 32'(rd_en), 32'd0);
        checkOutput("abort_hdr", (got.size() > 0) ? got[0] : 32'hxxxx_xxxx, 32'h8006_0020);
        got.delete();
        exp.delete();
        tick();
        expectLine(32'hA000_0003, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd3);
        waitAndCompare(100);

        // frame_start together with line_ready: line becomes line 0 of new frame.
        expectLine(32'hA000_0001, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'd1);
        waitAndCompare(100);

        // Saturating overrun counter, then asynchronous reset mid-line.
        readyLevel = 1'b0;
        repeat (2) tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd600);
        repeat (10) tick();
        for (int i = 0; i < 301; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 12'd5);
            tick();
        end
        checkOutput("overrun_sat", 32'(overrun_cnt), 32'd255);
        checkOutput("stuck_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_rd_bank", 32'(rd_bank), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun_cnt), 32'd0);
        @(negedge clk);
        #2;
        rst        = 1'b0;
        readyLevel = 1'b1;
        got.delete();
        repeat (2) tick();
        expectLine(32'hA000_0002, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd2);
        waitAndCompare(100);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/line_readout_scheduler.md
# line_readout_scheduler

Output-clock-domain controller that sequences reads of the ping-pong line RAM pair and streams completed lines to the 32-bit external receiver. It takes already-synchronized line-complete events (bank, word count), queues at most one pending line, prefixes each line with a header word, and drives RAM read address/enable with downstream ready/valid backpressure. It sits between the line-buffer write side and the USB FIFO interface, and replaces free-running read counters with a flow-controlled scheduler.

## Interface
- ADDR_WIDTH, 12, RAM read address width; line word count width; ≤16
- CNT_WIDTH, 12, line counter width; ≤12
- clk_i  in  1  output clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- frame_start_i  in  1  one-cycle pulse, new frame (synchronized)
- line_ready_i  in  1  one-cycle pulse, a line is fully written
- line_bank_i  in  1  bank holding that line, 0 = even RAM, 1 = odd RAM; valid with line_ready_i
- line_words_i  in  ADDR_WIDTH  32-bit words in that line; valid with line_ready_i
- rd_en_o  out  1  RAM read strobe
- rd_bank_o  out  1  RAM select for the read
- rd_addr_o  out  ADDR_WIDTH  RAM word address
- rd_data_i  in  32  RAM data, valid exactly 1 cycle after rd_en_o
- out_data_o  out  32  stream word
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready from receiver
- busy_o  out  1  high in any state other than IDLE, or while the output FIFO is non-empty
- overrun_cnt_o  out  8  count of dropped lines, saturating

## Operation
- Reset values: rd_en_o=0, rd_bank_o=0, rd_addr_o=0, out_valid_o=0, out_data_o=0, busy_o=0, overrun_cnt_o=0; line counter=0; sof flag=1; pending slot empty; FSM=IDLE.
- FSM states:
  - IDLE: if a line is available (pending slot, else line_ready_i this cycle), latch bank/words into the active registers, go to HEADER.
  - HEADER: push header word into the output FIFO when it has space. If words=0, increment the line counter and go to IDLE; otherwise go to STREAM.
  - STREAM: issue reads for addresses 0..words-1. After the last issue, go to DRAIN.
  - DRAIN: wait until the in-flight read lands. Then increment the line counter, clear sof, and go to IDLE.
- Header word: {2'b10, sof, 1'b0, line_cnt[11:0] zero-extended from CNT_WIDTH, 16'(line_words)}.
- Pending slot (depth 1):
  - line_ready_i while not in IDLE, or while the slot is already being consumed: store into the slot if it is empty.
  - If the slot is full: drop the new line and increment overrun_cnt_o, saturating at 255.
- Read issue rule: assert rd_en_o only if (FIFO occupancy + in-flight reads) < 2, or if that sum equals 2 and a pop occurs this cycle. With out_ready_i held high, throughput is 1 word/cycle.
- frame_start_i aborts any line in progress:
  - Next cycle: FSM=IDLE; pending slot, FIFO and in-flight reads discarded; out_valid_o=0; line counter=0; sof=1.
  - overrun_cnt_o is not cleared.
  - Simultaneous frame_start_i and line_ready_i: abort first, then the line is accepted as line 0 with sof=1.
- Stream rules:
  - out_data_o is held stable while out_valid_o && !out_ready_i.
  - out_valid_o never deasserts without a transfer, except on frame_start_i abort or rst_i.
- Line counter wraps modulo 2^CNT_WIDTH.

## Timing
- line_ready_i at cycle N in IDLE with an empty slot: HEADER at N+1, header valid on out_* at N+2.
- First rd_en_o at N+2 (address 0); first pixel word valid at N+4 if out_ready_i is high.
- Pending line starts HEADER on the cycle after DRAIN/HEADER exits to IDLE, i.e. one idle cycle between lines.
- rd_addr_o and rd_bank_o are registered; both are valid in the cycle rd_en_o is high.
- rst_i takes effect asynchronously. After release, the first action can occur on the second rising edge.

## Structure
- Package line_readout_pkg: FSM state enum (IDLE, HEADER, STREAM, DRAIN), header tag constant 2'b10, header field bit positions.
- Sub-module line_readout_fifo: 2-entry, 32-bit FIFO with push/pop/occupancy, registered head on out_data_o; instantiated once.
- Top contains the FSM, pending slot, address counter, in-flight flag and counters.

## Test plan
- frame_start, then line_ready (bank 0, words 4), ready high -> out stream 0xA000_0004, then RAM words 0..3 on consecutive cycles; busy_o low at the end.
- Two lines back to back with ready toggling 1/0 -> header line_cnt=1, sof=0 (0x8001_xxxx); no lost or duplicated words; data stable while stalled.
- Three line_ready pulses during one long line (words 64) -> second line streamed after the first; third dropped; overrun_cnt_o=1.
- line_ready with words=0 -> header only, no rd_en_o pulses, line_cnt increments.
- frame_start mid-STREAM (address 10 of 32) -> out_valid_o=0 next cycle; next line header has sof=1, line_cnt=0.
- 256 forced overruns -> overrun_cnt_o saturates at 255; rst_i asserted mid-line -> all outputs return to reset values immediately.
